// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer around a single 1-bit full adder
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    cnt;
    logic             c_reg;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] r_next;

    // The shared full-adder cell: one operand bit pair plus the registered carry.
    always_comb begin
        fa_sum  = a_sh[0] ^ b_sh[0] ^ c_reg;
        fa_cout = (a_sh[0] & b_sh[0]) | (c_reg & (a_sh[0] ^ b_sh[0]));
        a_next  = a_sh >> 1;
        b_next  = b_sh >> 1;
        r_next  = r_sh >> 1;
        r_next[WIDTH-1] = fa_sum;
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            cnt       <= '0;
            c_reg     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (clr) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= op_a;
                        b_sh  <= sub ? ~op_b : op_b;
                        c_reg <= sub;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh  <= a_next;
                    b_sh  <= b_next;
                    r_sh  <= r_next;
                    c_reg <= fa_cout;
                    if (cnt == LAST) begin
                        // c_reg still holds the carry into the top bit here.
                        result    <= r_next;
                        carry_out <= fa_cout;
                        overflow  <= c_reg ^ fa_cout;
                        cnt       <= '0;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
